uart_cmd_sequencer: RTL
=======================

# uart_cmd_sequencer

Sequencing controller between the UART RX FIFO and TX FIFO. It pops one received byte at a time and decodes the single-character commands 'r', 'c' and 'm' into one-cycle pulses. For each byte it pushes an acknowledge byte into the TX FIFO, then enforces a programmable hold-off before taking the next byte. It replaces level-held command outputs with a strict pop→decode→ack→hold sequence, so each byte yields exactly one pulse and one response.

## Interface
Parameters:
- HOLDOFF, 16, idle cycles inserted after each acknowledge push before the next pop (0 = none); counter width $clog2(HOLDOFF+1), min 1.
- ERR_BYTE, 8'h3F, acknowledge byte for an unrecognised command ('?').

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_empty  input  1  RX FIFO empty flag.
- rx_data  input  8  RX FIFO head byte, first-word-fall-through (valid whenever rx_empty=0).
- rx_pop  output  1  combinational pop strobe to RX FIFO.
- tx_full  input  1  TX FIFO full flag.
- tx_push  output  1  combinational push strobe to TX FIFO.
- tx_data  output  8  byte to push; valid when tx_push=1.
- o_cmd_run  output  1  one-cycle pulse on 'r' (8'h72).
- o_cmd_clear  output  1  one-cycle pulse on 'c' (8'h63).
- o_cmd_mode  output  1  one-cycle pulse on 'm' (8'h6D).
- o_busy  output  1  high whenever state != IDLE.
- o_cmd_cnt  output  8  count of valid commands, wraps 255→0.
- o_err_cnt  output  8  count of invalid bytes, saturates at 255.

## Operation
- FSM states: IDLE, DECODE, ACK, HOLD.
- IDLE:
  - rx_pop = !rx_empty.
  - On a pop, cmd_reg <= rx_data → DECODE.
  - Otherwise stay in IDLE.
- DECODE (always exactly 1 cycle):
  - Compare cmd_reg against 'r', 'c', 'm'. Exact 8-bit match; uppercase is invalid.
  - Valid: matching o_cmd_* <= 1, ack_reg <= cmd_reg, o_cmd_cnt += 1.
  - Invalid: ack_reg <= ERR_BYTE, o_err_cnt += 1 unless already 255.
  - → ACK.
- ACK:
  - o_cmd_* <= 0 at the first edge in ACK. Pulses are exactly one cycle wide regardless of stalls.
  - tx_push = !tx_full; tx_data = ack_reg.
  - On a push: → HOLD if HOLDOFF>0, else → IDLE, with the hold-off counter loaded to 0.
  - If tx_full: stay in ACK, no push. Stall is unbounded; no byte is dropped.
- HOLD:
  - Counter increments each cycle.
  - When it reaches HOLDOFF-1: → IDLE.
  - rx_pop is held at 0 throughout HOLD.
- rx_pop is 0 outside IDLE; tx_push is 0 outside ACK. They are never high in the same cycle.
- At most one o_cmd_* is high in any cycle.
- Reset values: state IDLE; cmd_reg=0, ack_reg=0, hold-off counter=0; o_cmd_* =0; o_cmd_cnt=0, o_err_cnt=0. Hence rx_pop=!rx_empty, tx_push=0, tx_data=0, o_busy=0.
- Reset mid-operation (any state): next cycle is IDLE with all registers at reset values. A pending ack is discarded; a pulse in flight is cut.

## Timing
- Byte popped at edge ending cycle N (IDLE, rx_pop=1).
  - DECODE in cycle N+1.
  - o_cmd_* high in cycle N+2 only.
  - tx_push earliest in cycle N+2.
- Counters update at the edge ending DECODE and are visible in N+2.
- With tx_full=0: next rx_pop earliest at cycle N+3+HOLDOFF. Throughput is one byte per 3+HOLDOFF cycles.
- tx_full rising in cycle N+2 delays the push. The pulse still occurs in N+2; HOLD starts after the actual push.
- rx_empty toggling outside IDLE is ignored.

## Test plan
- Reset, rx_empty=1 for 10 cycles → rx_pop=0, tx_push=0, all outputs 0, o_busy=0.
- HOLDOFF=16, FIFO holds "r","c","m", tx_full=0:
  - Exactly one pulse each on run, clear, mode, in that order, 19 cycles apart.
  - TX receives 8'h72, 8'h63, 8'h6D.
  - o_cmd_cnt=3, o_err_cnt=0.
- Byte 'R' (8'h52) then 8'h00:
  - No o_cmd_* pulses.
  - TX receives 8'h3F twice.
  - o_err_cnt=2.
  - Also 300 invalid bytes → o_err_cnt stays 255.
- 'r' popped, tx_full=1 for 20 cycles from cycle N+2:
  - o_cmd_run high only in N+2.
  - tx_push=0 for 20 cycles, then one push of 8'h72.
  - No further rx_pop until HOLDOFF cycles after that push.
- 256 valid 'c' commands → o_cmd_cnt wraps to 0; 256 clear pulses counted.
- rst asserted for 1 cycle while in ACK with tx_full=1 → no push afterwards, state IDLE, counters 0; the next queued byte is popped normally.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// Pop -> decode -> acknowledge -> hold-off sequencer between the UART RX and TX FIFOs.
// Each received byte yields exactly one command pulse (if valid) and exactly one TX acknowledge byte.
module uart_cmd_sequencer #(
  parameter int unsigned HOLDOFF  = 16,
  parameter logic [7:0]  ERR_BYTE = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  output logic       o_cmd_run,
  output logic       o_cmd_clear,
  output logic       o_cmd_mode,
  output logic       o_busy,
  output logic [7:0] o_cmd_cnt,
  output logic [7:0] o_err_cnt
);

  localparam int unsigned   CW        = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  localparam logic [7:0] CHAR_RUN   = 8'h72;
  localparam logic [7:0] CHAR_CLEAR = 8'h63;
  localparam logic [7:0] CHAR_MODE  = 8'h6D;

  typedef enum logic [1:0] {IDLE, DECODE, ACK, HOLD} state_t;

  state_t        state, state_nx;
  logic [7:0]    cmd_reg;
  logic [7:0]    ack_reg;
  logic [CW-1:0] hold_cnt;
  logic          is_run, is_clear, is_mode, is_valid;

  assign is_run   = (cmd_reg == CHAR_RUN);
  assign is_clear = (cmd_reg == CHAR_CLEAR);
  assign is_mode  = (cmd_reg == CHAR_MODE);
  assign is_valid = is_run | is_clear | is_mode;

  assign tx_data = ack_reg;
  assign o_busy  = (state != IDLE);

  always_comb begin
    state_nx = state;
    rx_pop   = 1'b0;
    tx_push  = 1'b0;
    case (state)
      IDLE: begin
        rx_pop = !rx_empty;
        if (!rx_empty) state_nx = DECODE;
      end
      DECODE: state_nx = ACK;
      ACK: begin
        tx_push = !tx_full;
        if (!tx_full) state_nx = (HOLDOFF > 0) ? HOLD : IDLE;
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_reg     <= '0;
      ack_reg     <= '0;
      hold_cnt    <= '0;
      o_cmd_run   <= 1'b0;
      o_cmd_clear <= 1'b0;
      o_cmd_mode  <= 1'b0;
      o_cmd_cnt   <= '0;
      o_err_cnt   <= '0;
    end else begin
      state <= state_nx;
      // Pulses are registered out of DECODE, so they cover only the first ACK cycle even under a TX stall.
      o_cmd_run   <= (state == DECODE) && is_run;
      o_cmd_clear <= (state == DECODE) && is_clear;
      o_cmd_mode  <= (state == DECODE) && is_mode;
      if (rx_pop) cmd_reg <= rx_data;
      if (state == DECODE) begin
        if (is_valid) begin
          ack_reg   <= cmd_reg;
          o_cmd_cnt <= o_cmd_cnt + 8'd1;
        end else begin
          ack_reg <= ERR_BYTE;
          if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        end
      end
      if (tx_push) hold_cnt <= '0;
      else if (state == HOLD) hold_cnt <= hold_cnt + CW'(1);
    end
  end

endmodule
